sd_sector_responder: RTL and testbench
======================================

Name: sd_sector_responder

Overview:
- Target end of the hps_io SD sector handshake (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*), serving 512-byte sectors from a local word-addressed backing store.
- Drops in wherever the backup-RAM save/load engine expects the HPS, e.g. a standalone simulation top or a local save-image store.
- Handles one sector per request: 256 16-bit words, strobed through sd_buff_* while sd_ack is high.

Parameters:
- LBA_BITS, 7, number of sector-index bits stored locally (capacity 2^LBA_BITS sectors; default 64 KB).
- ACK_DELAY, 4, cycles sd_ack is held high before the first word transfer (minimum 1).
- WORD_GAP, 0, idle cycles inserted after each word transfer.

Ports:
- clk_sys  in  1  system clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- sd_lba  in  32  sector number, sampled when a request is accepted.
- sd_rd  in  1  read request, level; the initiator holds it until sd_ack rises.
- sd_wr  in  1  write request, level.
- sd_ack  out  1  high for the whole sector transfer.
- sd_buff_addr  out  8  word index within the sector.
- sd_buff_dout  out  16  read data to the initiator.
- sd_buff_din  in  16  write data from the initiator; valid 1 cycle after sd_buff_addr.
- sd_buff_wr  out  1  1-cycle strobe marking sd_buff_dout / sd_buff_addr valid.
- mem_addr  out  LBA_BITS+8  backing-store word address = {lba[LBA_BITS-1:0], word}.
- mem_q  in  16  backing-store read data, 1-cycle latency after mem_addr.
- mem_d  out  16  backing-store write data.
- mem_we  out  1  backing-store write strobe.
- lba_err  out  1  sticky: a request hit an LBA >= 2^LBA_BITS.
- sector_sum  out  16  checksum of the last sector; see Optional Feature.

Behaviour:
- Reset values: sd_ack=0, sd_buff_wr=0, mem_we=0, sd_buff_addr=0, sd_buff_dout=0, mem_addr=0, mem_d=0, lba_err=0, sector_sum=0, state=IDLE.
- Reset mid-sector: all strobes and sd_ack go low on the next edge; words already written stay in the store.
- States: IDLE, ACKW, RADR, RDAT, WADR, WDAT, GAP, DONE.
- IDLE: entered with sd_ack low.
  - If sd_rd or sd_wr is high: latch sd_lba, latch op (rd wins when both are high), word=0, raise sd_ack, go to ACKW.
  - Set oor = (sd_lba >= 2^LBA_BITS); if oor, set lba_err.
- ACKW: count ACK_DELAY cycles, then go to RADR (read) or WADR (write).
- RADR: mem_addr={lba,word}; next state RDAT.
- RDAT:
  - sd_buff_dout = oor ? 0 : mem_q; sd_buff_addr=word; sd_buff_wr=1 for exactly this cycle.
  - Next: GAP if WORD_GAP>0; otherwise continue.
- WADR: sd_buff_addr=word, mem_addr={lba,word}; next state WDAT.
- WDAT: mem_d=sd_buff_din; mem_we = ~oor for exactly 1 cycle.
- Continue rule (after RDAT, WDAT or GAP): if word==255 go to DONE; else word+1 (8-bit) and return to RADR or WADR.
- GAP: WORD_GAP cycles, then apply the continue rule.
- Throughput with WORD_GAP=0: 2 cycles per word, so sd_ack is high for ACK_DELAY+512+1 cycles.
- DONE: sd_ack=0; go to IDLE. sd_ack is guaranteed low for at least 1 cycle before a new request is accepted, because IDLE samples requests only while sd_ack is low.
- Back-to-back multi-sector transfers: the initiator re-raises rd/wr on the ack falling edge; this is accepted on the first IDLE cycle.
- Request changes while busy (including sd_rd/sd_wr dropping) are ignored; each accepted sector always runs to completion.
- Only lba[LBA_BITS-1:0] forms the address. lba_err clears only on reset.

Optional Feature:
- Macro: SD_RESP_CHECKSUM_EN.
- Defined:
  - Accumulator is cleared on accept.
  - Each transferred word is added modulo 2^16: sd_buff_dout on reads, sd_buff_din on writes.
  - sector_sum is updated in DONE and held until the next DONE.
- Undefined: sector_sum is tied to 0 and no accumulator logic is generated.

Test Plan:
1. Read: preload store sector 3 with word i = i*3; pulse sd_rd with lba=3; drop sd_rd on ack rise -> exactly 256 sd_buff_wr strobes, addr 0..255, dout=i*3; ack high ACK_DELAY+513 cycles.
2. Write: sd_wr with lba=5; initiator BRAM returns 16'hA500+addr one cycle after addr -> store words 0x500..0x5FF hold A500..A5FF; mem_we pulses exactly 256 times.
3. 128-sector burst, initiator-style: lba 0..127 sequential reads with the request re-raised on the ack fall -> 128 ack pulses, each preceded by at least 1 low cycle; no word lost or duplicated.
4. Out-of-range: read with lba=128 (LBA_BITS=7) -> 256 strobes of 0, lba_err=1; then write with lba=200 -> mem_we never asserted, lba_err stays 1.
5. Simultaneous sd_rd=sd_wr=1 -> read performed, mem_we=0. Reset asserted at word 100 of a write -> sd_ack=0 next cycle; words 0..99 retained; next request starts at word 0.
6. SD_RESP_CHECKSUM_EN: read of a sector containing all 16'h0101 -> sector_sum=16'h0100 (256*0x0101 mod 2^16). Without the macro -> sector_sum stays 0.

Source files
------------

// File: rtl/sd_sector_if.sv
// SD sector handshake between an hps_io-style initiator (master) and a sector
// responder (slave): request, ack and the per-word sd_buff_* strobes.
interface sd_sector_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic [15:0] sd_buff_din;
  logic        sd_buff_wr;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/sd_sector_responder.sv
// Serves 512-byte sectors (256 x 16-bit words) from a word-addressed backing store.
// Define SD_RESP_CHECKSUM_EN to build the per-sector word checksum on sector_sum.
module sd_sector_responder #(
  parameter int LBA_BITS  = 7,
  parameter int ACK_DELAY = 4,
  parameter int WORD_GAP  = 0
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  sd_sector_if.slave            sd,
  output logic [LBA_BITS+7:0]   mem_addr,
  input  logic [15:0]           mem_q,
  output logic [15:0]           mem_d,
  output logic                  mem_we,
  output logic                  lba_err,
  output logic [15:0]           sector_sum
);

  typedef enum logic [2:0] {
    IDLE, ACKW, RADR, RDAT, WADR, WDAT, GAP, DONE
  } state_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_DELAY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((WORD_GAP > 0) ? WORD_GAP - 1 : 0);

  state_e              state_q, state_d;
  logic [LBA_BITS-1:0] lba_q, lba_d;
  logic [7:0]          word_q, word_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic                oor_q, oor_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                do_continue;

  logic        req;
  logic        lba_oor;
  logic [15:0] rd_data;

  assign req     = sd.sd_rd | sd.sd_wr;
  assign lba_oor = (sd.sd_lba >> LBA_BITS) != 32'd0;
  assign rd_data = (state_q == RDAT && !oor_q) ? mem_q : 16'h0000;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    state_d     = state_q;
    lba_d       = lba_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    oor_d       = oor_q;
    ack_d       = ack_q;
    err_d       = err_q;
    do_continue = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          lba_d   = sd.sd_lba[LBA_BITS-1:0];
          rd_d    = sd.sd_rd;
          word_d  = 8'd0;
          cnt_d   = '0;
          oor_d   = lba_oor;
          ack_d   = 1'b1;
          state_d = ACKW;
          if (lba_oor) err_d = 1'b1;
        end
      end
      ACKW: begin
        if (cnt_q == ACK_LAST) state_d = rd_q ? RADR : WADR;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      RADR: state_d = RDAT;
      WADR: state_d = WDAT;
      RDAT, WDAT: begin
        if (WORD_GAP > 0) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          do_continue = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) do_continue = 1'b1;
        else                   cnt_d       = cnt_q + CNT_W'(1);
      end
      DONE: begin
        // ack stays high through DONE and falls as IDLE is entered
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_continue) begin
      if (word_q == 8'hFF) begin
        state_d = DONE;
      end else begin
        word_d  = word_q + 8'd1;
        state_d = rd_q ? RADR : WADR;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q <= IDLE;
      lba_q   <= '0;
      word_q  <= 8'd0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lba_q   <= lba_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      oor_q   <= oor_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign sd.sd_ack       = ack_q;
  assign sd.sd_buff_addr = word_q;
  assign sd.sd_buff_wr   = (state_q == RDAT);
  assign sd.sd_buff_dout = rd_data;
  assign mem_addr        = {lba_q, word_q};
  assign mem_we          = (state_q == WDAT) && !oor_q;
  assign mem_d           = (state_q == WDAT) ? sd.sd_buff_din : 16'h0000;
  assign lba_err         = err_q;

`ifdef SD_RESP_CHECKSUM_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] sum_q, sum_d;

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    case (state_q)
      IDLE:    if (req) acc_d = 16'h0000;
      RDAT:    acc_d = acc_q + rd_data;
      WDAT:    acc_d = acc_q + sd.sd_buff_din;
      DONE:    sum_d = acc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_q <= 16'h0000;
      sum_q <= 16'h0000;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign sector_sum = sum_q;
`else
  assign sector_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_sd_sector_responder.sv
// Self-checking bench: sector-timeline reference model plus store scoreboard,
// directed sector scenarios and a few randomized requests.
module tb_sd_sector_responder;
  localparam int LBA_BITS  = 7;
  localparam int ACK_DELAY = 4;
  localparam int WORD_GAP  = 0;
  localparam int PER       = 2 + WORD_GAP;
  localparam int TXN_LEN   = ACK_DELAY + 256 * PER + 1;
  localparam int MEM_WORDS = 1 << (LBA_BITS + 8);
  localparam logic [32:0] NUM_SECT = 33'd1 << LBA_BITS;

  logic                clk_sys;
  logic                reset;
  logic [LBA_BITS+7:0] mem_addr;
  logic [15:0]         mem_q;
  logic [15:0]         mem_d;
  logic                mem_we;
  logic                lba_err;
  logic [15:0]         sector_sum;

  sd_sector_if sd_bus ();

  sd_sector_responder #(
    .LBA_BITS (LBA_BITS),
    .ACK_DELAY(ACK_DELAY),
    .WORD_GAP (WORD_GAP)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .sd        (sd_bus),
    .mem_addr  (mem_addr),
    .mem_q     (mem_q),
    .mem_d     (mem_d),
    .mem_we    (mem_we),
    .lba_err   (lba_err),
    .sector_sum(sector_sum)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 25) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation ran out of time");
    $fatal(1, "watchdog expired");
  end

  // Backing store with 1-cycle read latency, and the expected store contents
  logic [15:0] mem     [0:MEM_WORDS-1];
  logic [15:0] exp_mem [0:MEM_WORDS-1];
  logic [LBA_BITS+7:0] ram_a;
  logic                ram_we;
  logic [15:0]         ram_d;

  initial begin
    mem_q = 16'h0000;
    forever begin
      @(negedge clk_sys);
      ram_a  = mem_addr;
      ram_we = mem_we;
      ram_d  = mem_d;
      @(posedge clk_sys);
      #1;
      if (ram_we === 1'b1) mem[ram_a] = ram_d;
      mem_q = mem[ram_a];
    end
  end

  // Initiator buffer: returns wbase + addr one cycle after sd_buff_addr
  logic [15:0] wbase;
  logic [7:0]  din_a;

  initial begin
    sd_bus.sd_buff_din = 16'h0000;
    forever begin
      @(negedge clk_sys);
      din_a = sd_bus.sd_buff_addr;
      @(posedge clk_sys);
      #1;
      sd_bus.sd_buff_din = wbase + {8'h00, din_a};
    end
  end

  // Reference model: each accepted sector is a fixed timeline of TXN_LEN ack-high
  // cycles, word j transferred at cycle ACK_DELAY + 1 + j*PER after accept.
  bit                  busy = 1'b0;
  int                  k    = 0;
  bit                  m_rd;
  bit                  m_oor;
  bit                  m_err = 1'b0;
  logic [LBA_BITS-1:0] m_lba;
  logic [15:0]         m_wbase;
  logic [15:0]         m_acc;
  logic [15:0]         m_sum = 16'h0000;
  int                  mdl_j;

  function automatic int slot(input int kk);
    int d;
    if (kk < ACK_DELAY + 1) return -1;
    d = kk - ACK_DELAY - 1;
    if ((d % PER) != 0 || (d / PER) > 255) return -1;
    return d / PER;
  endfunction

  initial begin
    forever begin
      @(posedge clk_sys);
      if (reset) begin
        busy  = 1'b0;
        k     = 0;
        m_err = 1'b0;
        m_sum = 16'h0000;
      end else if (busy) begin
        mdl_j = slot(k);
        if (!m_rd && !m_oor && mdl_j >= 0)
          exp_mem[{m_lba, mdl_j[7:0]}] = m_wbase + mdl_j[15:0];
        k++;
        if (k == TXN_LEN) begin
          busy  = 1'b0;
          m_sum = m_acc;
        end
      end else if (sd_bus.sd_rd || sd_bus.sd_wr) begin
        busy    = 1'b1;
        k       = 0;
        m_rd    = sd_bus.sd_rd;
        m_lba   = sd_bus.sd_lba[LBA_BITS-1:0];
        m_oor   = {1'b0, sd_bus.sd_lba} >= NUM_SECT;
        m_wbase = wbase;
        if (m_oor) m_err = 1'b1;
        m_acc = 16'h0000;
        for (int i = 0; i < 256; i++) begin
          if (m_rd) m_acc = m_acc + (m_oor ? 16'h0000 : exp_mem[{m_lba, i[7:0]}]);
          else      m_acc = m_acc + m_wbase + i[15:0];
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every cycle after reset
  bit                  mon_en = 1'b0;
  int                  mon_j;
  logic [LBA_BITS+7:0] mon_idx;

  initial begin
    forever begin
      @(negedge clk_sys);
      if (mon_en) begin
        mon_j   = busy ? slot(k) : -1;
        mon_idx = {m_lba, mon_j[7:0]};
        check("sd_ack", sd_bus.sd_ack, busy);
        check("sd_buff_wr", sd_bus.sd_buff_wr, (mon_j >= 0) && m_rd);
        if (mon_j >= 0 && m_rd) begin
          check("buff_addr", sd_bus.sd_buff_addr, mon_j);
          check("buff_dout", sd_bus.sd_buff_dout, m_oor ? 16'h0000 : exp_mem[mon_idx]);
        end
        check("mem_we", mem_we, (mon_j >= 0) && !m_rd && !m_oor);
        if (mon_j >= 0 && !m_rd) begin
          check("mem_addr", mem_addr, mon_idx);
          check("mem_d", mem_d, m_wbase + mon_j[15:0]);
        end
        check("lba_err", lba_err, m_err);
`ifdef SD_RESP_CHECKSUM_EN
        check("sector_sum", sector_sum, m_sum);
`else
        check("sector_sum", sector_sum, 16'h0000);
`endif
      end
    end
  end

  // Per-pulse statistics used by the hand-computed expectations
  bit          ack_prev   = 1'b0;
  int          cur_len    = 0;
  int          cur_str    = 0;
  int          cur_we     = 0;
  int          first_addr = -1;
  logic [15:0] last_dout  = 16'h0000;
  int          ack_len    = 0;
  int          str_cnt    = 0;
  int          we_last    = 0;
  int          pulses     = 0;
  int          low_run    = 0;
  int          min_low    = 1000000;

  initial begin
    forever begin
      @(negedge clk_sys);
      if (sd_bus.sd_ack === 1'b1) begin
        if (!ack_prev) begin
          if (low_run < min_low) min_low = low_run;
          cur_len    = 0;
          cur_str    = 0;
          cur_we     = 0;
          first_addr = -1;
        end
        cur_len++;
        if (sd_bus.sd_buff_wr === 1'b1) begin
          cur_str++;
          if (first_addr < 0) first_addr = int'(sd_bus.sd_buff_addr);
          last_dout = sd_bus.sd_buff_dout;
        end
        if (mem_we === 1'b1) cur_we++;
        ack_prev = 1'b1;
      end else begin
        if (ack_prev) begin
          ack_len = cur_len;
          str_cnt = cur_str;
          we_last = cur_we;
          pulses++;
          low_run = 0;
        end
        low_run++;
        ack_prev = 1'b0;
      end
    end
  end

  task automatic sync();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string what);
    int n = 0;
    while (sd_bus.sd_ack !== lvl && n < budget) begin
      sync();
      n++;
    end
    check(what, sd_bus.sd_ack, lvl);
  endtask

  // Called just after a rising edge; returns just after the ack-falling edge
  task automatic do_sector(input bit rd, input bit wr, input logic [31:0] lba,
                           input logic [15:0] base);
    wbase         = base;
    sd_bus.sd_lba = lba;
    sd_bus.sd_rd  = rd;
    sd_bus.sd_wr  = wr;
    wait_ack(1'b1, 8, "ack_rise");
    sd_bus.sd_rd  = 1'b0;
    sd_bus.sd_wr  = 1'b0;
    sd_bus.sd_lba = $urandom();
    wait_ack(1'b0, TXN_LEN + 8, "ack_fall");
  endtask

  logic [15:0] saved_word;
  int          p0;
  int          n_wait;
  bit          r_rd;
  bit          r_wr;

  initial begin
    reset         = 1'b1;
    sd_bus.sd_lba = 32'h0;
    sd_bus.sd_rd  = 1'b0;
    sd_bus.sd_wr  = 1'b0;
    wbase         = 16'h0000;
    for (int a = 0; a < MEM_WORDS; a++) begin
      mem[a]     = 16'($urandom());
      exp_mem[a] = mem[a];
    end
    for (int i = 0; i < 256; i++) begin
      mem[3*256 + i]     = 16'(i * 3);
      exp_mem[3*256 + i] = 16'(i * 3);
    end

    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_ack", sd_bus.sd_ack, 1'b0);
    check("rst_buff_wr", sd_bus.sd_buff_wr, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_buff_addr", sd_bus.sd_buff_addr, 8'h00);
    check("rst_buff_dout", sd_bus.sd_buff_dout, 16'h0000);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_d", mem_d, 16'h0000);
    check("rst_lba_err", lba_err, 1'b0);
    check("rst_sum", sector_sum, 16'h0000);
    reset  = 1'b0;
    mon_en = 1'b1;
    sync();

    // Read of sector 3 holding i*3
    do_sector(1'b1, 1'b0, 32'd3, 16'h0000);
    settle();
    check("t1_strobes", str_cnt, 256);
    check("t1_ack_len", ack_len, ACK_DELAY + 513);
    check("t1_first_addr", first_addr, 0);
    check("t1_last_dout", last_dout, 16'h02FD);
    check("t1_no_we", we_last, 0);
    sync();

    // Write of sector 5 from an initiator buffer holding A500+addr
    do_sector(1'b0, 1'b1, 32'd5, 16'hA500);
    settle();
    check("t2_we_count", we_last, 256);
    check("t2_no_strobe", str_cnt, 0);
    check("t2_word0", mem[16'h0500], 16'hA500);
    check("t2_word255", mem[16'h05FF], 16'hA5FF);
    sync();

    // Out-of-range read, then out-of-range write
    do_sector(1'b1, 1'b0, 32'd128, 16'h0000);
    settle();
    check("t4_oor_strobes", str_cnt, 256);
    check("t4_oor_dout", last_dout, 16'h0000);
    check("t4_lba_err", lba_err, 1'b1);
    sync();
    do_sector(1'b0, 1'b1, 32'd200, 16'h1234);
    settle();
    check("t4_oor_no_we", we_last, 0);
    check("t4_err_sticky", lba_err, 1'b1);
    sync();

    // rd and wr together: read wins
    do_sector(1'b1, 1'b1, 32'd3, 16'h7777);
    settle();
    check("t5_rdwr_strobes", str_cnt, 256);
    check("t5_rdwr_no_we", we_last, 0);
    sync();

    // Reset at word 100 of a write to sector 6
    saved_word    = mem[6*256 + 100];
    wbase         = 16'h6000;
    sd_bus.sd_lba = 32'd6;
    sd_bus.sd_wr  = 1'b1;
    wait_ack(1'b1, 8, "t5_ack_rise");
    sd_bus.sd_wr = 1'b0;
    n_wait = 0;
    while (cur_we < 100 && n_wait < 2 * TXN_LEN) begin
      sync();
      n_wait++;
    end
    check("t5_reached_w100", cur_we, 100);
    reset = 1'b1;
    sync();
    check("t5_rst_ack_low", sd_bus.sd_ack, 1'b0);
    check("t5_rst_we_low", mem_we, 1'b0);
    reset = 1'b0;
    check("t5_word99_kept", mem[6*256 + 99], 16'h6063);
    check("t5_word100_untouched", mem[6*256 + 100], saved_word);
    sync();
    do_sector(1'b1, 1'b0, 32'd6, 16'h0000);
    settle();
    check("t5_restart_addr", first_addr, 0);
    check("t5_restart_strobes", str_cnt, 256);
    sync();

    // Back-to-back burst over every sector, request re-raised on the ack fall
    p0      = pulses;
    min_low = 1000000;
    for (int s = 0; s < 128; s++) do_sector(1'b1, 1'b0, 32'(s), 16'h0000);
    settle();
    check("t3_pulses", pulses - p0, 128);
    check("t3_low_gap_ge1", min_low >= 1, 1'b1);
    check("t3_last_len", ack_len, TXN_LEN);
    sync();

    // Checksum of a sector of 0x0101 words
    for (int i = 0; i < 256; i++) begin
      mem[9*256 + i]     = 16'h0101;
      exp_mem[9*256 + i] = 16'h0101;
    end
    do_sector(1'b1, 1'b0, 32'd9, 16'h0000);
    settle();
`ifdef SD_RESP_CHECKSUM_EN
    check("t6_sum", sector_sum, 16'h0100);
`else
    check("t6_sum_off", sector_sum, 16'h0000);
`endif
    sync();

    // Randomized requests over in-range and out-of-range sectors
    for (int t = 0; t < 4; t++) begin
      r_rd = 1'($urandom());
      r_wr = ~r_rd | 1'($urandom());
      do_sector(r_rd, r_wr, 32'($urandom_range(0, 255)), 16'($urandom()));
    end
    settle();
    sync();

    for (int a = 0; a < MEM_WORDS; a++)
      check($sformatf("store[%0h]", a), mem[a], exp_mem[a]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
